alu_sequencer: RTL and testbench

Program sequencer for the 8-bit ALU. It holds a small instruction buffer loaded by the host, then on `start` issues each instruction to the ALU in order. It synchronises to the free-running ALU pass cycle, captures each result, and hands it to a downstream consumer over a valid/ready handshake. It sits between the host/control bus and the ALU and is the only driver of the ALU's operand, opcode and enable inputs.

---
 rtl/alu_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Program sequencer for the 8-bit ALU. The host loads a small instruction
//   buffer. A start request then issues each instruction to the ALU in order.
//   The sequencer synchronises to the ALU's free-running pass, captures each
//   result and offers it downstream over a valid/ready handshake.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   prog_we/addr/data  instruction buffer write port
//                      (data: [20:17] op, [16] acc, [15:8] a, [7:0] b)
//   prog_len           number of instructions to run, sampled on start
//   start              one-cycle run request
//   busy, run_done     run in progress; one-cycle end-of-run pulse
//   err                sticky misuse flag (start or write while busy)
//   alu_a/b/op/acc/en  operands, opcode, accumulator select and enable to the ALU
//   alu_results        ALU result input
//   alu_done           ALU completion pulse
//   res_valid/data/idx result offered downstream, with its instruction index
//   res_ready          result accepted by the downstream consumer
module alu_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [20:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic          busy,
    output logic          run_done,
    output logic          err,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_op,
    output logic          alu_acc,
    output logic          alu_en,
    input  logic [7:0]    alu_results,
    input  logic          alu_done,
    output logic          res_valid,
    output logic [7:0]    res_data,
    output logic [AW-1:0] res_idx,
    input  logic          res_ready
);

    localparam logic [3:0]  OP_NOP = 4'hF;
    localparam logic [AW:0] ONE    = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SYNC,
        S_EXEC,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t         state_q;
    logic [AW:0]    pc_q;
    logic [AW:0]    prog_len_q;
    logic           busy_q;
    logic           run_done_q;
    logic           err_q;
    logic [7:0]     alu_a_q;
    logic [7:0]     alu_b_q;
    logic [3:0]     alu_op_q;
    logic           alu_acc_q;
    logic           alu_en_q;
    logic           res_valid_q;
    logic [7:0]     res_data_q;
    logic [AW-1:0]  res_idx_q;

    // Instruction buffer: no reset, so contents survive a reset.
    logic [20:0]    mem_q [DEPTH];
    logic [20:0]    fetch_d;
    logic           last_d;

    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign fetch_d = mem_q[pc_q[AW-1:0]];
    // pc and length are AW+1 bits wide so a full-depth run ends without wrapping.
    assign last_d  = (pc_q == prog_len_q - ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            prog_len_q  <= '0;
            busy_q      <= 1'b0;
            run_done_q  <= 1'b0;
            err_q       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_acc_q   <= 1'b0;
            alu_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
        end else begin
            run_done_q <= 1'b0;

            // Misuse during a run: the request or write is dropped, only flagged.
            if (busy_q && (start || prog_we)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (prog_len == '0) begin
                            run_done_q <= 1'b1;
                        end else begin
                            err_q      <= 1'b0;
                            pc_q       <= '0;
                            prog_len_q <= prog_len;
                            busy_q     <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    if (fetch_d[20:17] == OP_NOP) begin
                        state_q <= S_FINISH;
                    end else begin
                        alu_op_q  <= fetch_d[20:17];
                        alu_acc_q <= fetch_d[16];
                        alu_a_q   <= fetch_d[15:8];
                        alu_b_q   <= fetch_d[7:0];
                        alu_en_q  <= 1'b1;
                        state_q   <= S_SYNC;
                    end
                end

                // The first completion after new operands may come from a pass
                // that started with the old ones, so it is thrown away.
                S_SYNC: begin
                    if (alu_done) begin
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (alu_done) begin
                        res_data_q  <= alu_results;
                        res_idx_q   <= pc_q[AW-1:0];
                        res_valid_q <= 1'b1;
                        // Result captured: the instruction is no longer in flight.
                        alu_en_q    <= 1'b0;
                        state_q     <= S_EMIT;
                    end
                end

                // The next instruction is not fetched until the result is taken,
                // which keeps accumulator chains strictly in order.
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (last_d) begin
                            state_q <= S_FINISH;
                        end else begin
                            pc_q    <= pc_q + ONE;
                            state_q <= S_FETCH;
                        end
                    end
                end

                S_FINISH: begin
                    busy_q     <= 1'b0;
                    alu_en_q   <= 1'b0;
                    run_done_q <= 1'b1;
                    state_q    <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign run_done  = run_done_q;
    assign err       = err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_acc   = alu_acc_q;
    assign alu_en    = alu_en_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a free-running 5-cycle ALU model and a
// program-level reference model for the expected result stream.
module tb_alu_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [20:0]   prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          busy, run_done, err;
    logic [7:0]    alu_a, alu_b;
    logic [3:0]    alu_op;
    logic          alu_acc, alu_en;
    logic [7:0]    alu_results = 8'd0;
    logic          alu_done = 1'b0;
    logic          res_valid;
    logic [7:0]    res_data;
    logic [AW-1:0] res_idx;
    logic          res_ready = 1'b0;

    alu_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_len(prog_len), .start(start),
        .busy(busy), .run_done(run_done), .err(err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_acc(alu_acc),
        .alu_en(alu_en), .alu_results(alu_results), .alu_done(alu_done),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 inc, 6 transfer_a, 7 dec, 15 nop.
    function automatic logic [7:0] op_eval(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a + 8'd1;
            4'd6:    return a;
            4'd7:    return a - 8'd1;
            default: return a;
        endcase
    endfunction

    // ALU model: wait, load A, load B, compute, done. The accumulator takes the
    // last result whenever a new instruction is enabled.
    logic [2:0] ph = 3'd0;
    logic [7:0] la = 8'd0, lb = 8'd0, acc_r = 8'd0;
    logic [3:0] lop = 4'd0;
    logic       en_prev = 1'b0;

    always @(posedge clk) begin
        ph       <= (ph == 3'd4) ? 3'd0 : ph + 3'd1;
        alu_done <= (ph == 3'd3);
        en_prev  <= alu_en;
        if (alu_en && !en_prev) acc_r <= alu_results;
        case (ph)
            3'd1: la <= alu_a;
            3'd2: begin
                lb  <= alu_acc ? acc_r : alu_b;
                lop <= alu_op;
            end
            3'd3: alu_results <= op_eval(lop, la, lb);
            default: ;
        endcase
    end

    int         total = 0;
    int         bad = 0;
    logic [20:0] shadow [DEPTH];
    logic [7:0] ref_acc = 8'd0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [20:0] mk(input logic [3:0] op, input logic acc,
                                       input logic [7:0] a, input logic [7:0] b);
        return {op, acc, a, b};
    endfunction

    // Reference: walk the program in order, stop at the first nop, chain the accumulator.
    function automatic void build_expect(input int len);
        logic [7:0] acc;
        logic [7:0] bop;
        logic [7:0] r;
        exp_q.delete();
        acc = ref_acc;
        for (int i = 0; i < len; i++) begin
            if (shadow[i][20:17] == 4'hF) break;
            bop = shadow[i][16] ? acc : shadow[i][7:0];
            r = op_eval(shadow[i][20:17], shadow[i][15:8], bop);
            exp_q.push_back(r);
            acc = r;
        end
    endfunction

    task automatic load(input int addr, input logic [20:0] data);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = data;
        shadow[addr] = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic run_prog(input int len, input bit hold, input bit inject);
        int  k, cyc;
        bit  seen, finished, just_acc, stable;
        logic [7:0] d0;
        logic [3:0] op0;
        build_expect(len);
        got_q.delete();
        k = 0; cyc = 0; seen = 0; finished = 0; just_acc = 0;
        prog_len = (AW+1)'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(len > 0));
        while (!finished && cyc < 3000) begin
            if (inject && cyc == 3) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = '0;
                prog_data = mk(4'd0, 1'b0, 8'h20, 8'h20);
            end else if (inject && cyc == 4) begin
                start = 1'b0; prog_we = 1'b0;
            end
            if (just_acc) begin
                chk("valid_drop", 32'(res_valid), 32'd0);
                just_acc = 0;
            end
            if (run_done) begin
                finished = 1;
            end else begin
                if (res_valid) begin
                    if (!seen) begin
                        if (k < exp_q.size()) begin
                            chk("res_data", 32'(res_data), 32'(exp_q[k]));
                            chk("res_idx", 32'(res_idx), 32'(k));
                        end else begin
                            chk("extra_result", 32'(k), 32'(exp_q.size()));
                        end
                        got_q.push_back(res_data);
                        seen = 1;
                        if (hold && k == 0) begin
                            d0 = res_data; op0 = alu_op; stable = 1; res_ready = 1'b0;
                            repeat (20) begin
                                @(negedge clk); cyc++;
                                if (!(res_valid === 1'b1 && res_data === d0 &&
                                      res_idx === '0 && alu_op === op0)) stable = 0;
                            end
                            chk("hold_stable", 32'(stable), 32'd1);
                        end
                    end
                    res_ready = (hold && k == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    if (res_ready) begin
                        k++; seen = 0; just_acc = 1;
                    end
                end else begin
                    res_ready = ($urandom_range(0, 1) != 0);
                end
                @(negedge clk); cyc++;
            end
        end
        chk("run_done_seen", 32'(finished), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("result_count", 32'(k), 32'(exp_q.size()));
        res_ready = 1'b0;
        @(negedge clk);
        chk("run_done_one_cycle", 32'(run_done), 32'd0);
        if (exp_q.size() > 0) ref_acc = exp_q[exp_q.size()-1];
    endtask

    initial begin
        int cyc, nd, len;
        logic [3:0] op;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 32'({busy, run_done, err, alu_en, res_valid, alu_acc}), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        chk("rst_res", 32'({res_data, res_idx}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-instruction program
        load(0, mk(4'd0, 1'b0, 8'd5, 8'd3));
        load(1, mk(4'd1, 1'b0, 8'd9, 8'd4));
        run_prog(2, 0, 0);
        chk("basic_r0", 32'(got_q.size() > 0 ? got_q[0] : 8'hXX), 32'd8);
        chk("basic_r1", 32'(got_q.size() > 1 ? got_q[1] : 8'hXX), 32'd5);

        // Accumulator chaining
        load(0, mk(4'd6, 1'b0, 8'd7, 8'd0));
        load(1, mk(4'd0, 1'b1, 8'd2, 8'h55));
        run_prog(2, 0, 0);
        chk("chain_r0", 32'(got_q.size() > 0 ? got_q[0] : 8'hXX), 32'd7);
        chk("chain_r1", 32'(got_q.size() > 1 ? got_q[1] : 8'hXX), 32'd9);

        // Backpressure on the first result
        load(0, mk(4'd0, 1'b0, 8'd5, 8'd3));
        load(1, mk(4'd1, 1'b0, 8'd9, 8'd4));
        run_prog(2, 1, 0);
        chk("hold_r1", 32'(got_q.size() > 1 ? got_q[1] : 8'hXX), 32'd5);

        // Nop halts the run
        load(0, mk(4'd5, 1'b0, 8'hFF, 8'd0));
        load(1, mk(4'hF, 1'b0, 8'd0, 8'd0));
        load(2, mk(4'd0, 1'b0, 8'd1, 8'd1));
        run_prog(3, 0, 0);
        chk("nop_count", 32'(got_q.size()), 32'd1);
        chk("nop_r0", 32'(got_q.size() > 0 ? got_q[0] : 8'hXX), 32'd0);

        // Zero-length run
        run_prog(0, 0, 0);

        // Misuse during a run
        load(0, mk(4'd0, 1'b0, 8'd5, 8'd3));
        load(1, mk(4'd1, 1'b0, 8'd9, 8'd4));
        run_prog(2, 0, 1);
        chk("err_set", 32'(err), 32'd1);
        run_prog(2, 0, 0);
        chk("err_cleared", 32'(err), 32'd0);
        chk("buf_kept_r0", 32'(got_q.size() > 0 ? got_q[0] : 8'hXX), 32'd8);

        // Reset in the middle of EXEC
        prog_len = (AW+1)'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!alu_en && cyc < 50) begin @(negedge clk); cyc++; end
        while (!alu_done && cyc < 50) begin @(negedge clk); cyc++; end
        chk("reach_exec", 32'(cyc < 50), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", 32'({busy, run_done, err, alu_en, res_valid, alu_acc}), 32'd0);
        chk("midrst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        chk("midrst_res", 32'({res_data, res_idx}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (run_done) nd++;
        end
        chk("no_done_after_rst", 32'(nd), 32'd0);
        ref_acc = 8'd0;
        run_prog(2, 0, 0);
        chk("rerun_r0", 32'(got_q.size() > 0 ? got_q[0] : 8'hXX), 32'd8);
        chk("rerun_r1", 32'(got_q.size() > 1 ? got_q[1] : 8'hXX), 32'd5);

        // Random programs
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                op = ($urandom_range(0, 11) == 0) ? 4'hF : 4'($urandom_range(0, 7));
                load(i, mk(op, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom)));
            end
            len = (r == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            run_prog(len, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
